// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: LSB-first words of WIDTH bits, registered serial sum,
// parallel result rebuild, and per-word carry-out / signed overflow flags.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             sub,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             out_valid,
  output logic             f,
  output logic             word_done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic               out_valid_q, out_valid_d;
  logic               f_q, f_d;
  logic               word_done_q, word_done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               accept_c;
  logic               mode_c;
  logic               cin_c;
  logic               bb_c;
  logic               sum_c;
  logic               carry_nx_c;
  logic [CNT_W-1:0]   idx_c;
  logic [WIDTH-1:0]   shifted_c;

  // Bit-level datapath; an sof bit restarts the word with carry-in = sub (two's complement).
  always_comb begin
    accept_c   = 1'b0;
    mode_c     = mode_q;
    cin_c      = carry_q;
    idx_c      = cnt_q;
    bb_c       = 1'b0;
    sum_c      = 1'b0;
    carry_nx_c = 1'b0;
    shifted_c  = sreg_q;

    accept_c = in_valid && (in_sof || (state_q == RUN));
    if (in_sof) begin
      mode_c = sub;
      cin_c  = sub;
      idx_c  = '0;
    end
    bb_c       = b ^ mode_c;
    sum_c      = a ^ bb_c ^ cin_c;
    carry_nx_c = (a & bb_c) | (a & cin_c) | (bb_c & cin_c);
    shifted_c  = {sum_c, sreg_q[WIDTH-1:1]};
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    sreg_d      = sreg_q;
    out_valid_d = 1'b0;
    f_d         = 1'b0;
    word_done_d = 1'b0;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE, RUN: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          f_d         = sum_c;
          mode_d      = mode_c;
          carry_d     = carry_nx_c;
          sreg_d      = shifted_c;
          if (idx_c == LAST_IDX) begin
            // Carry into the MSB is this bit's carry-in; overflow when it differs from carry-out.
            state_d     = IDLE;
            cnt_d       = '0;
            word_done_d = 1'b1;
            result_d    = shifted_c;
            cout_d      = carry_nx_c;
            ovf_d       = cin_c ^ carry_nx_c;
          end else begin
            state_d = RUN;
            cnt_d   = idx_c + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      sreg_q      <= '0;
      out_valid_q <= 1'b0;
      f_q         <= 1'b0;
      word_done_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      sreg_q      <= sreg_d;
      out_valid_q <= out_valid_d;
      f_q         <= f_d;
      word_done_q <= word_done_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign out_valid = out_valid_q;
  assign f         = f_q;
  assign word_done = word_done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed vector table, corner sequences,
// and random words against an arithmetic reference model.
module tb_serial_addsub;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic         sub = 1'b0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         busy;
  logic         out_valid;
  logic         f;
  logic         word_done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .sub(sub),
    .a(a), .b(b), .busy(busy), .out_valid(out_valid), .f(f), .word_done(word_done),
    .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic [W-1:0] stall;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         expq[$];
  int           checks = 0;
  int           errors = 0;
  logic         exp_acc = 1'b0;
  logic         exp_done = 1'b0;
  logic         in_word = 1'b0;
  int           nbits = 0;
  logic [W-1:0] fword = '0;
  logic [W-1:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Plain-integer reference: wrap result, unsigned carry / not-borrow, signed range overflow.
  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int ux, uy, sx, sy, r, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      r      = ux + uy;
      sr     = sx + sy;
      e.cout = (r > 255);
    end else begin
      r      = ux - uy;
      sr     = sx - sy;
      e.cout = (ux >= uy);
    end
    e.res = r[W-1:0];
    e.ovf = (sr > 127) || (sr < -128);
    return e;
  endfunction

  task automatic observe();
    exp_t e;
    chk("out_valid", 32'(out_valid), 32'(exp_acc));
    chk("word_done", 32'(word_done), 32'(exp_done));
    chk("busy", 32'(busy), 32'(in_word));
    if (out_valid) fword = {f, fword[W-1:1]};
    if (word_done) begin
      if (expq.size() == 0) begin
        chk("spurious_word_done", 32'(1), 32'(0));
      end else begin
        e = expq.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("f_stream", 32'(fword), 32'(e.res));
        last_res = e.res;
      end
    end else begin
      chk("result_hold", 32'(result), 32'(last_res));
    end
  endtask

  // One clock: check outputs caused by the previous cycle, then drive the next inputs.
  task automatic tick(input logic v, input logic s, input logic sb, input logic ai, input logic bi);
    @(negedge clk);
    observe();
    in_valid = v;
    in_sof   = s;
    sub      = sb;
    a        = ai;
    b        = bi;
    exp_acc  = v && (s || in_word);
    exp_done = 1'b0;
    if (exp_acc) begin
      if (s) nbits = 0;
      nbits++;
      in_word = 1'b1;
      if (nbits == int'(W)) begin
        in_word  = 1'b0;
        exp_done = 1'b1;
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                           input logic [W-1:0] stall, input exp_t e);
    expq.push_back(e);
    for (int i = 0; i < int'(W); i++) begin
      tick(1'b1, i == 0, (i == 0) ? s : 1'($urandom), x[i], y[i]);
      if (stall[i]) begin
        repeat (3) tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[10];
  exp_t e;

  initial begin
    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 8'h33, 8'h44, 8'h77, 1'b0, 1'b0, 8'h24};
    vecs[6] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[8] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 8'h00};
    vecs[9] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1, 8'h00};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_f", 32'(f), 32'(0));
    chk("rst_word_done", 32'(word_done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;

    // Idle bits without sof are ignored.
    repeat (3) tick(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));

    // Directed table, words sent back-to-back (stall mask bits 2 and 5 on the 0x33+0x44 row).
    for (int i = 0; i < 10; i++) begin
      e.res  = vecs[i].res;
      e.cout = vecs[i].cout;
      e.ovf  = vecs[i].ovf;
      send_word(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].stall, e);
    end
    idle_ticks(2);

    // Abort: 0xAA+0x55 restarted at bit 4 by 0x09-0x03.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] pa, pb;
      pa = 8'hAA;
      pb = 8'h55;
      tick(1'b1, i == 0, 1'b0, pa[i], pb[i]);
    end
    e.res = 8'h06; e.cout = 1'b1; e.ovf = 1'b0;
    send_word(8'h09, 8'h03, 1'b1, 8'h00, e);
    idle_ticks(2);

    // Reset asserted at bit 3 of a word.
    for (int i = 0; i < 3; i++) tick(1'b1, i == 0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    observe();
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_word = 1'b0;
    nbits = 0;
    exp_acc = 1'b0;
    exp_done = 1'b0;
    last_res = '0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_word_done", 32'(word_done), 32'(0));
    chk("mid_rst_result", 32'(result), 32'(0));
    chk("mid_rst_cout", 32'(cout), 32'(0));
    chk("mid_rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0;
    repeat (4) tick(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom));
    send_word(8'h12, 8'h34, 1'b0, 8'h00, model(1'b0, 8'h12, 8'h34));
    idle_ticks(1);

    // Random words against the reference model, with random stalls and idle noise.
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] ra, rb, st;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      st = (($urandom % 4) == 0) ? W'($urandom) & W'($urandom) : '0;
      send_word(ra, rb, rs, st, model(rs, ra, rb));
      if (($urandom % 5) == 0) tick(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle_ticks(3);
    chk("queue_empty", 32'(expq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
